// File: rtl/timer_pkg.sv
// Shared state encoding and default sizes for the down-counting timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned TIMER_WIDTH_DEF = 32;
  localparam int unsigned TIMER_EVT_W_DEF = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Divides RUN cycles by PRESCALE: tick_o is high on the enabled cycle where the
// phase counter sits at PRESCALE-1; the counter then wraps to 0.
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == PW'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Loadable WIDTH-bit countdown timer with run/pause, one-shot/auto-reload, done pulse
// and saturating expiry count. TIMER_PRESCALE_EN inserts a divide-by-PRESCALE tick.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH    = TIMER_WIDTH_DEF,
  parameter int PRESCALE = 4,
  parameter int EVT_W    = TIMER_EVT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             auto_reload_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [EVT_W-1:0] events_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [EVT_W-1:0] events_q, events_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef TIMER_PRESCALE_EN
  logic pre_en, pre_clr;

  // Load or stop on this edge must not advance the phase; IDLE keeps it at 0.
  assign pre_en  = (state_q == ST_RUN) && !load_en_i && !stop_i;
  assign pre_clr = load_en_i || (state_q == ST_IDLE);

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pre_en),
    .clr_i  (pre_clr),
    .tick_o (tick)
  );
`else
  // No division: every RUN cycle is a tick (PRESCALE is always >= 2, so this is 1).
  assign tick = (PRESCALE >= 1);
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    events_d = events_q;
    done_d   = 1'b0;
    if (load_en_i) begin
      reload_d = load_value_i;
      count_d  = load_value_i;
      events_d = '0;
      state_d  = ST_IDLE;
    end else if (stop_i) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (count_q != '0) state_d = ST_RUN;
            else               done_d  = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            // RUN is only entered with a non-zero count, so anything not above 1 is expiry.
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              done_d = 1'b1;
              if (events_q != '1) events_d = events_q + EVT_W'(1);
              if (auto_reload_i && (reload_q != '0)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_IDLE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      events_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      events_q <= events_d;
      done_q   <= done_d;
    end
  end

  assign count_o  = count_q;
  assign busy_o   = (state_q == ST_RUN);
  assign done_o   = done_q;
  assign events_o = events_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; cycle expectations scale by TK when TIMER_PRESCALE_EN is set.
module tb_timer_counter;

`ifdef TIMER_PRESCALE_EN
  localparam int TK = 4;
`else
  localparam int TK = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        load_en_i;
  logic [31:0] load_value_i;
  logic        start_i;
  logic        stop_i;
  logic        auto_reload_i;
  logic [31:0] count_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  events_o;

  int passed = 0;
  int total  = 0;

  timer_counter #(.WIDTH(32), .PRESCALE(4), .EVT_W(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .load_en_i     (load_en_i),
    .load_value_i  (load_value_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .auto_reload_i (auto_reload_i),
    .count_o       (count_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .events_o      (events_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tk();
    repeat (TK) step();
  endtask

  task automatic load(input logic [31:0] v);
    load_en_i = 1'b1; load_value_i = v;
    step();
    load_en_i = 1'b0;
  endtask

  task automatic start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; load_en_i = 1'b0; load_value_i = '0;
    start_i = 1'b0; stop_i = 1'b0; auto_reload_i = 1'b0;
    #12;
    chk("rst_count", count_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_count", count_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_events", events_o, 0);
    end

    // One-shot from 5.
    load(5);
    start();
    chk("os_busy_start", busy_o, 1);
    chk("os_count_start", count_o, 5);
    for (int i = 4; i >= 0; i--) begin
      tk();
      chk("os_count", count_o, i);
      chk("os_done", done_o, (i == 0));
    end
    chk("os_busy_end", busy_o, 0);
    chk("os_events", events_o, 1);
    step();
    chk("os_done_single", done_o, 0);

    // Auto-reload period 3 over 10 ticks.
    auto_reload_i = 1'b1;
    load(3);
    start();
    for (int e = 1; e <= 10; e++) begin
      tk();
      chk("ar_count", count_o, (e % 3 == 1) ? 2 : (e % 3 == 2) ? 1 : 3);
      chk("ar_done", done_o, (e % 3 == 0));
      chk("ar_busy", busy_o, 1);
    end
    chk("ar_events", events_o, 3);
    auto_reload_i = 1'b0;

    // Pause and resume.
    load(10);
    chk("pr_events_cleared", events_o, 0);
    chk("pr_busy_after_load", busy_o, 0);
    start();
    repeat (4) tk();
    chk("pr_count_before_stop", count_o, 6);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pr_hold_count", count_o, 6);
      chk("pr_hold_busy", busy_o, 0);
      step();
    end
    start();
    chk("pr_resume_busy", busy_o, 1);
    for (int i = 5; i >= 0; i--) begin
      tk();
      chk("pr_count", count_o, i);
      chk("pr_done", done_o, (i == 0));
    end
    chk("pr_events", events_o, 1);

    // Start with zero count.
    load(0);
    start();
    chk("z_done", done_o, 1);
    chk("z_busy", busy_o, 0);
    chk("z_count", count_o, 0);
    step();
    chk("z_done_drop", done_o, 0);

    // Load on the expiry edge wins.
    load(2);
    start();
    tk();
    chk("le_count_pre", count_o, 1);
    repeat (TK - 1) step();
    load(7);
    chk("le_done", done_o, 0);
    chk("le_events", events_o, 0);
    chk("le_count", count_o, 7);
    chk("le_busy", busy_o, 0);

    // Stop on the expiry edge wins.
    load(1);
    start();
    repeat (TK - 1) step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("se_done", done_o, 0);
    chk("se_events", events_o, 0);
    chk("se_count", count_o, 1);
    chk("se_busy", busy_o, 0);

    // Two-tick expiry lands exactly 2*TK cycles after start.
    load(2);
    start();
    repeat (2 * TK - 1) step();
    chk("p2_done_early", done_o, 0);
    step();
    chk("p2_done", done_o, 1);
    chk("p2_events", events_o, 1);

    // Reload 1: back-to-back expiries and event saturation.
    auto_reload_i = 1'b1;
    load(1);
    start();
    repeat (300 * TK - 3 * TK) step();
    for (int i = 0; i < 3; i++) begin
      tk();
      chk("b2b_done", done_o, 1);
      chk("b2b_count", count_o, 1);
    end
    chk("sat_events", events_o, 255);
    chk("sat_busy", busy_o, 1);

    // Asynchronous reset mid-RUN.
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_rst_count", count_o, 0);
    chk("ar_rst_busy", busy_o, 0);
    chk("ar_rst_done", done_o, 0);
    chk("ar_rst_events", events_o, 0);
    rst_ni = 1'b1;
    step();
    start();
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_count", count_o, 0);
    auto_reload_i = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Parametrised down-counting timer: generalises the fixed 5-bit toggle counter into a WIDTH-bit loadable countdown with run/pause control, one-shot or auto-reload mode, a one-cycle expiry pulse, and a saturating expiry-event counter. Sits beside the register file as a memory-mapped timer source for processor interrupts and sonar ping scheduling.

## Interface
- WIDTH, 32, bit width of the reload and count registers (2..32)
- PRESCALE, 4, cycles per count tick; used only when TIMER_PRESCALE_EN is defined (>= 2)
- EVT_W, 8, width of the expiry-event counter
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low; asserting 0 immediately clears all state
- load_en  in  1  write load_value into reload and count registers
- load_value  in  WIDTH  reload value
- start  in  1  begin or resume counting
- stop  in  1  pause counting
- auto_reload  in  1  1 = periodic, 0 = one-shot; sampled at every expiry
- count  out  WIDTH  current count register
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse following an expiry
- events  out  EVT_W  saturating number of expiries since last load

## Operation
- States: IDLE, RUN, PAUSE. Reset: state IDLE, count 0, reload 0, busy 0, done 0, events 0, prescaler 0.
- Priority per edge: load_en > stop > start.
- load_en (any state): reload <= load_value, count <= load_value, events <= 0, state -> IDLE, pending tick discarded.
- start in IDLE, count != 0: -> RUN, prescaler cleared. start in IDLE, count == 0: done pulses, stay IDLE. start in PAUSE: -> RUN, prescaler kept. start in RUN: ignored.
- stop in RUN: -> PAUSE, count and prescaler held. stop in IDLE/PAUSE: ignored.
- Tick in RUN with count > 1: count <= count - 1.
- Tick in RUN with count == 1 (expiry): done pulses; events <= events + 1, holding at 2^EVT_W - 1. auto_reload = 1 and reload != 0: count <= reload, stay RUN. Otherwise: count <= 0, -> IDLE.
- Expiry period = reload ticks exactly; no extra reload cycle.
- busy = (state == RUN), combinational from state register.

## Timing
- Without prescaler: one tick per cycle in RUN, starting the cycle after entry to RUN. Load 3, start at edge 0 -> count 2, 1, 0 after edges 1, 2, 3; done high for the cycle after edge 3; busy low from edge 3.
- done is registered, exactly one cycle wide; back-to-back expiries with reload 1 give done high every cycle.
- load_en or stop on the expiry edge wins; no done, no event increment.
- Reset mid-RUN: all outputs drop to reset values asynchronously; counting resumes only after a new load and start.
- count wraps never: the down-counter never decrements below 0.

## Configuration
- TIMER_PRESCALE_EN defined: prescaler counts 0..PRESCALE-1 in RUN; a tick occurs when it reaches PRESCALE-1, then it wraps to 0. Expiry period = reload × PRESCALE cycles. Prescaler cleared on load and on IDLE->RUN, held in PAUSE.
- Undefined: no prescaler logic; tick every RUN cycle; PRESCALE ignored.

## Structure
- timer_pkg: state encodings (IDLE, RUN, PAUSE) and default WIDTH/EVT_W constants.
- One sub-module, timer_prescaler (enable, clear, tick out), instantiated only under TIMER_PRESCALE_EN.
- Count, reload and event registers are plain flops with async active-low clear.

## Test plan
- Reset release, no stimulus -> count 0, busy 0, done 0, events 0 for 20 cycles.
- Load 5, one-shot, start -> count 4..0 on 5 successive edges, single done pulse, busy low, events 1.
- Load 3, auto_reload 1, start, run 10 cycles -> done on cycles 3, 6, 9; count 3->2->1->3 pattern; events 3.
- Load 10, start, stop after 4 ticks, idle 5 cycles, start -> count held at 6 while paused, expiry 6 ticks after resume.
- Load 0, start -> done pulses next cycle, state stays IDLE; load on an expiry edge -> no done, events 0.
- TIMER_PRESCALE_EN, PRESCALE 4, load 2, start -> done after 8 cycles; events saturate at 255 with reload 1 running 300 cycles.
